// File: rtl/pwm_timing_gen_if.sv
// Handshake bundle between the PWM control FSM and its timing front end.
// master = FSM (drives reset_contador/pwm), slave = pwm_timing_gen.
interface pwm_timing_gen_if;
    logic reset_contador;
    logic pwm;
    logic reset_contador_in;
    logic comp_frecuencia;
    logic comp_corriente;

    modport master (
        output reset_contador,
        output pwm,
        input  reset_contador_in,
        input  comp_frecuencia,
        input  comp_corriente
    );

    modport slave (
        input  reset_contador,
        input  pwm,
        output reset_contador_in,
        output comp_frecuencia,
        output comp_corriente
    );
endinterface

// File: rtl/pwm_timing_gen.sv
// Timing/sensing front end for the PWM control FSM: start pulse, period
// compare, blanked+filtered current compare, t_max clamp, soft start, fault.
// Ports: clock/reset/enable, fsm (slave handshake), periodo/t_max,
// i_sense/i_ref/i_lim, cuenta, i_ref_eff, fault. All outputs registered.
module pwm_timing_gen #(
    parameter int CNT_W   = 16,
    parameter int ADC_W   = 10,
    parameter int BLANK   = 4,
    parameter int FILT    = 2,
    parameter int GAP_MIN = 3,
    parameter int SS_STEP = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    pwm_timing_gen_if.slave  fsm,
    input  logic [CNT_W-1:0] periodo,
    input  logic [CNT_W-1:0] t_max,
    input  logic [ADC_W-1:0] i_sense,
    input  logic [ADC_W-1:0] i_ref,
    input  logic [ADC_W-1:0] i_lim,
    output logic [CNT_W-1:0] cuenta,
    output logic [ADC_W-1:0] i_ref_eff,
    output logic             fault
);
    localparam int GW = $clog2(GAP_MIN + 1);
    localparam int BW = $clog2(BLANK + 1);

    typedef enum logic [1:0] {S_OFF, S_SOFT, S_RUN, S_FAULT} state_t;

    state_t           r_state;
    logic             r_arm;
    logic [GW-1:0]    r_gap;
    logic [BW-1:0]    r_blank;
    logic [2:0]       r_filt;
    logic             r_pwm_d;
    logic [CNT_W-1:0] r_per_lat;
    logic [CNT_W-1:0] r_tmax_lat;
    logic [CNT_W-1:0] r_cnt;
    logic [ADC_W-1:0] r_eff;
    logic             r_fault;
    logic             r_rci;
    logic             r_cf;
    logic             r_cc;

    logic             w_rc;
    logic             w_pwm;
    logic             w_ovc;
    logic             w_active;
    logic             w_gap_ok;
    logic             w_start;
    logic [CNT_W-1:0] w_per;
    logic [CNT_W-1:0] w_per_m1;
    logic [CNT_W-1:0] w_tmax;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W:0]   w_cnt_inc;
    logic             w_rise;
    logic             w_blanked;
    logic             w_qual;
    logic [2:0]       w_filt_nxt;
    logic [BW-1:0]    w_blank_nxt;
    logic [ADC_W:0]   w_ss;
    logic [ADC_W-1:0] w_ss_sat;
    logic             w_fault_nxt;
    logic             w_cc_nxt;
    logic             w_cf_nxt;

    assign w_rc     = fsm.reset_contador;
    assign w_pwm    = fsm.pwm;
    assign w_ovc    = (i_sense >= i_lim);
    assign w_active = (r_state == S_SOFT) || (r_state == S_RUN);
    // r_gap counts prior consecutive idle clocks; current one must be idle too
    assign w_gap_ok = (r_gap >= GW'(GAP_MIN));
    // overcurrent in the same clock suppresses the start
    assign w_start  = enable && w_active && w_rc && w_gap_ok
                    && r_arm && !w_ovc;

    assign w_per    = (periodo < CNT_W'(2)) ? CNT_W'(2) : periodo;
    assign w_per_m1 = w_per - CNT_W'(1);
    assign w_tmax   = (t_max < w_per_m1) ? t_max : w_per_m1;

    assign w_cnt_nxt = w_rc ? '0
                     : (&r_cnt ? r_cnt : r_cnt + CNT_W'(1));
    assign w_cnt_inc = {1'b0, w_cnt_nxt} + (CNT_W+1)'(1);

    // blanking window: the rising-edge sample plus BLANK-1 after it
    assign w_rise      = w_pwm && !r_pwm_d;
    assign w_blanked   = w_rise || (r_blank != '0);
    assign w_blank_nxt = w_rise ? BW'(BLANK - 1)
                       : ((r_blank != '0) ? r_blank - BW'(1) : '0);

    assign w_qual     = w_pwm && !w_blanked && (i_sense >= r_eff);
    assign w_filt_nxt = !w_qual ? 3'd0
                      : ((r_filt == 3'd7) ? r_filt : r_filt + 3'd1);

    assign w_ss     = {1'b0, r_eff} + (ADC_W+1)'(SS_STEP);
    assign w_ss_sat = (w_ss >= {1'b0, i_ref}) ? i_ref : w_ss[ADC_W-1:0];

    assign w_fault_nxt = enable && (r_fault || (w_active && w_ovc));

    // next-cycle values so the registered flags line up with cuenta
    assign w_cc_nxt = (w_filt_nxt >= 3'(FILT))
                    || (w_pwm && (w_cnt_nxt >= r_tmax_lat))
                    || w_fault_nxt
                    || !enable;
    assign w_cf_nxt = !w_rc && (w_cnt_inc >= {1'b0, r_per_lat});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_OFF;
            r_arm      <= 1'b1;
            r_gap      <= '0;
            r_blank    <= '0;
            r_filt     <= '0;
            r_pwm_d    <= 1'b0;
            r_per_lat  <= '0;
            r_tmax_lat <= '0;
            r_cnt      <= '0;
            r_eff      <= '0;
            r_fault    <= 1'b0;
            r_rci      <= 1'b0;
            r_cf       <= 1'b0;
            r_cc       <= 1'b0;
        end else begin
            r_rci   <= w_start;
            r_cf    <= w_cf_nxt;
            r_cc    <= w_cc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fault <= w_fault_nxt;
            r_filt  <= w_filt_nxt;
            r_blank <= w_blank_nxt;
            r_pwm_d <= w_pwm;

            if (!w_rc)
                r_gap <= '0;
            else if (!w_gap_ok)
                r_gap <= r_gap + GW'(1);

            // re-arm only once the FSM has visibly left idle
            if (w_start) begin
                r_arm      <= 1'b0;
                r_per_lat  <= w_per;
                r_tmax_lat <= w_tmax;
            end else if (!w_rc) begin
                r_arm <= 1'b1;
            end

            if (!enable) begin
                r_state <= S_OFF;
                r_eff   <= '0;
            end else begin
                unique case (r_state)
                    S_OFF: begin
                        r_state <= S_SOFT;
                        r_eff   <= '0;
                    end
                    S_SOFT: begin
                        if (w_ovc) begin
                            r_state <= S_FAULT;
                        end else begin
                            if (r_eff >= i_ref)
                                r_state <= S_RUN;
                            if (w_start)
                                r_eff <= w_ss_sat;
                        end
                    end
                    S_RUN: begin
                        if (w_ovc)
                            r_state <= S_FAULT;
                        else
                            r_eff <= i_ref;
                    end
                    S_FAULT: r_state <= S_FAULT;
                    default: r_state <= S_OFF;
                endcase
            end
        end
    end

    assign fsm.reset_contador_in = r_rci;
    assign fsm.comp_frecuencia   = r_cf;
    assign fsm.comp_corriente    = r_cc;
    assign cuenta                = r_cnt;
    assign i_ref_eff             = r_eff;
    assign fault                 = r_fault;
endmodule
